barrel_shift_reg: RTL
=====================

// Module: barrel_shift_reg
// PURPOSE
// Parametrised WIDTH-bit rotate/shift register. It is stepped by an asynchronous push-button
// (synchronised, rising-edge detected) or by an internal auto-step timer. Each step applies one
// op (load/rotate/shift) by a programmable amount to the held value. It drives board LEDs
// directly and replaces the fixed 8-bit, button-clocked rotator. It is fully synchronous to clk.
// PARAMETERS
// WIDTH   8          register width; must be a power of two, >= 2
// SHAMT_W $clog2(WIDTH) shift-amount width (derived; do not override)
// INIT    8'h80      value loaded on reset and by op CLR (WIDTH bits)
// PERIOD  50_000_000 auto-step interval in clk cycles; >= 2
// PORTS
// clk      in  1        system clock, rising edge
// rst      in  1        async reset, active-low (0 = reset)
// step     in  1        raw push-button, asynchronous to clk, active-high
// auto_en  in  1        1 = auto-step timer runs
// op       in  3        operation applied on each step event (table below)
// shamt    in  SHAMT_W  shift/rotate amount, 0..WIDTH-1
// load_val in  WIDTH    value for op LOAD
// q        out WIDTH    register value (LEDs)
// upd      out 1        1-cycle pulse, high in the cycle q takes its new value
// step_cnt out 16       count of applied step events, wraps 16'hFFFF -> 0
// BEHAVIOUR
// - Reset (rst=0, async): q=INIT, upd=0, step_cnt=0, sync flops=0, edge flop=0, timer=0.
// - Button path: 2-flop synchroniser s1->s2, then edge flop s3.
//   btn_ev = s2 & ~s3. A step rising edge becomes btn_ev after 2 clk edges; q updates on the 3rd edge.
//   A button held high across reset release produces exactly one btn_ev. There is no debounce:
//   every synchronised rising edge is a step.
// - Timer: runs only when auto_en=1. It counts 0..PERIOD-1. At terminal count auto_ev=1 for one
//   cycle and the timer wraps to 0. auto_en=0 clears the timer to 0 synchronously.
//   The first auto_ev comes PERIOD cycles after auto_en rises.
// - ev = btn_ev | auto_ev. If both occur in the same cycle, exactly one op is applied.
// - On a clk edge with ev=1: q <= f(op,q); upd <= 1; step_cnt <= step_cnt+1.
//   Otherwise q holds and upd <= 0. upd is registered, so it is high in the cycle after the edge.
// - op and shamt are sampled in the ev cycle. Changing them between events has no effect on q.
// - op table:
//   000 HOLD: q unchanged. upd and step_cnt still update.
//   001 LOAD: q <= load_val
//   010 ROL: rotate left by shamt
//   011 ROR: rotate right by shamt
//   100 SLL: logical shift left by shamt, zero fill
//   101 SRL: logical shift right by shamt, zero fill
//   110 SRA: arithmetic shift right by shamt, fill with q[WIDTH-1]
//   111 CLR: q <= INIT
// - shamt=0: all rotates and shifts leave q unchanged, but it still counts as an event.
// - Arithmetic is exactly WIDTH bits; bits shifted out are discarded. Rotation modulo WIDTH is
//   implicit because shamt < WIDTH.
// - Shifter is combinational (log2 stages). Result is registered only; there is no pipeline
//   latency beyond the 1 cycle from ev to q.
// - Reset asserted mid-operation: all state returns to reset values immediately. Pending sync
//   flop contents are lost and no event is generated from them.
// TESTING (WIDTH=8, INIT=8'h80, PERIOD=4 for sim)
// 1 reset, op=ROR, shamt=1, pulse step 3 times (>=4 clk each) -> q=40,20,10; 3 upd pulses;
//   step_cnt=3; each upd 3 edges after step rise
// 2 op=LOAD, load_val=8'hB1, step; then op=ROL, shamt=3, step -> q=B1, then 8D; op=SRA,
//   shamt=2 on q=8D -> E3; op=SRL -> 23
// 3 auto_en=1, op=ROR, shamt=1, step=0 -> q changes every 4 cycles; auto_en=0 for 2 cycles,
//   then 1 -> next upd exactly 4 cycles later
// 4 step rise aligned so btn_ev coincides with auto_ev -> single ROR (q 80->40), step_cnt+1
//   only, one upd
// 5 step held high 20 cycles, step glitch shorter than 1 clk -> exactly 1 event for the hold;
//   glitch yields 0 or 1 event, never 2
// 6 rst low mid-sequence (q=8'h23, timer mid-count) -> q=80, step_cnt=0, upd=0 asynchronously;
//   step_cnt 16'hFFFF + event -> 0

Source files
------------

// File: rtl/barrel_shift_reg.sv
// barrel_shift_reg
// WIDTH-bit rotate/shift register stepped either by a raw push-button
// (synchronised and rising-edge detected) or by an internal auto-step timer.
// Each step applies one operation (load/rotate/shift/clear) by a programmable
// amount to the held value. Fully synchronous to clk.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   step     in   raw push-button, asynchronous to clk, active-high
//   auto_en  in   1 = auto-step timer runs; 0 clears it
//   op       in   operation applied on each step event
//   shamt    in   shift/rotate amount, 0..WIDTH-1
//   load_val in   value for LOAD
//   q        out  register value
//   upd      out  1-cycle pulse in the cycle q takes its new value
//   step_cnt out  count of applied step events (wraps)
module barrel_shift_reg #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      SHAMT_W = $clog2(WIDTH),
  parameter logic [WIDTH-1:0] INIT    = 8'h80,
  parameter int unsigned      PERIOD  = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               auto_en,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   q,
  output logic               upd,
  output logic [15:0]        step_cnt
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ROL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam int unsigned     TW       = $clog2(PERIOD);
  localparam logic [TW-1:0]   TMR_LAST = TW'(PERIOD - 1);

  // Button synchroniser (s1, s2) and edge-detect flop (s3)
  logic s1_q, s2_q, s3_q;
  logic btn_ev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= step;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s3 resets to 0, so a button held through reset release still yields one event
  assign btn_ev = s2_q & ~s3_q;

  // Auto-step timer
  logic [TW-1:0] tmr_q, tmr_d;
  logic          auto_ev;

  assign auto_ev = auto_en && (tmr_q == TMR_LAST);

  always_comb begin
    tmr_d = tmr_q;
    if (!auto_en)
      tmr_d = '0;
    else if (tmr_q == TMR_LAST)
      tmr_d = '0;
    else
      tmr_d = tmr_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tmr_q <= '0;
    else
      tmr_q <= tmr_d;
  end

  // Combined event: simultaneous button and timer events apply a single op
  logic ev;
  assign ev = btn_ev | auto_ev;

  // Log2-stage shifters, one stage per shamt bit
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rol_v, ror_v, sll_v, srl_v, sra_v;

  always_comb begin
    rol_v = q_q;
    ror_v = q_q;
    sll_v = q_q;
    srl_v = q_q;
    sra_v = q_q;
    for (int unsigned k = 0; k < SHAMT_W; k++) begin
      if (shamt[k]) begin
        rol_v = (rol_v << (32'd1 << k)) | (rol_v >> (WIDTH - (32'd1 << k)));
        ror_v = (ror_v >> (32'd1 << k)) | (ror_v << (WIDTH - (32'd1 << k)));
        sll_v = sll_v << (32'd1 << k);
        srl_v = srl_v >> (32'd1 << k);
        sra_v = $signed(sra_v) >>> (32'd1 << k);
      end
    end
  end

  always_comb begin
    q_d = q_q;
    case (op)
      OP_HOLD: q_d = q_q;
      OP_LOAD: q_d = load_val;
      OP_ROL:  q_d = rol_v;
      OP_ROR:  q_d = ror_v;
      OP_SLL:  q_d = sll_v;
      OP_SRL:  q_d = srl_v;
      OP_SRA:  q_d = sra_v;
      OP_CLR:  q_d = INIT;
      default: q_d = q_q;
    endcase
  end

  // Result, update strobe and event counter
  logic        upd_q;
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= INIT;
      upd_q <= 1'b0;
      cnt_q <= '0;
    end else if (ev) begin
      q_q   <= q_d;
      upd_q <= 1'b1;
      cnt_q <= cnt_q + 16'd1;
    end else begin
      upd_q <= 1'b0;
    end
  end

  assign q        = q_q;
  assign upd      = upd_q;
  assign step_cnt = cnt_q;

endmodule
